operand_stack: RTL
==================

OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, maximum stacked entries; power of two, at least 4.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1, command present this cycle.
REQ-006 SHALL have port cmd, input, 3, command code: NOP=0, PUSH=1, POP=2, DUP=3, SWAP=4, REPL2=5; codes 6-7 illegal.
REQ-007 SHALL have port din, input, WIDTH, operand for PUSH, or ALU result for REPL2.
REQ-008 SHALL have port tos, output, WIDTH, registered top-of-stack.
REQ-009 SHALL have port nos, output, WIDTH, registered next-on-stack.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1, registered entry count.
REQ-011 SHALL have ports empty and full, output, 1 each; decoded from count (count==0, count==DEPTH).
REQ-012 SHALL have port err, output, 1, error flag (see REQ-024).
REQ-013 SHALL have port err_code, output, 2: 0 none, 1 underflow, 2 overflow, 3 illegal cmd.

Function
REQ-014 SHALL apply each accepted command in exactly one cycle; tos, nos and count SHALL reflect it on the next edge; there SHALL be no backpressure.
REQ-015 PUSH SHALL set nos<=tos, tos<=din, count+1; legal only when count<DEPTH.
REQ-016 POP SHALL set tos<=nos, nos<=entry below, count-1; legal only when count>=1.
REQ-017 DUP SHALL set nos<=tos, count+1, tos unchanged; legal only when 1<=count<DEPTH.
REQ-018 SWAP SHALL exchange tos and nos, count unchanged; legal only when count>=2.
REQ-019 REPL2 SHALL set tos<=din, nos<=entry below the old nos, count-1; legal only when count>=2.
REQ-020 tos/nos SHALL read 0 whenever the corresponding position is unoccupied (count<1 or count<2).
REQ-021 cmd_valid=0 or cmd=NOP SHALL leave all state unchanged.
REQ-022 Any illegal command (underflow, overflow, or code 6-7) SHALL leave the stack contents and count unchanged and SHALL set err_code on the next edge.
REQ-023 When several error conditions apply, illegal code SHALL take priority over underflow or overflow.
REQ-024 Default, without the macro: err SHALL pulse high for one cycle per illegal command, and err_code SHALL hold its value for that cycle only.

Reset
REQ-025 On reset the block SHALL set count=0, tos=0, nos=0, err=0, err_code=0; storage contents need not be cleared.
REQ-026 Reset SHALL override any cmd_valid in the same cycle.

Configuration
REQ-027 SHALL use macro OPERAND_STACK_TRAP_EN.
REQ-028 With OPERAND_STACK_TRAP_EN defined: err and err_code SHALL be sticky after the first error, and all later commands SHALL be ignored until reset (trap).
REQ-029 With OPERAND_STACK_TRAP_EN undefined: the block SHALL behave per REQ-024 and continue accepting commands.

Structure
REQ-030 Shared package proc0_pkg SHALL hold the cmd encoding constants, the err_code constants and the default WIDTH/DEPTH.
REQ-031 Storage below nos SHALL be a sub-module stack_regfile: DEPTH-2 entries, one write port, one async read port, indexed by count.
REQ-032 tos and nos SHALL be dedicated registers in operand_stack.

Verification
REQ-033 Reset, then PUSH 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, count=3.
REQ-034 From REQ-033 state: SWAP, then POP -> after SWAP tos=0x22, nos=0x33; after POP tos=0x33, nos=0x11, count=2.
REQ-035 With tos=0x05, nos=0x03, count=2: REPL2 with din=0x08 -> tos=0x08, nos=0, count=1.
REQ-036 POP on empty -> err=1, err_code=1, count=0; then PUSH 0x44 -> count=1 without the macro, still count=0 with the macro.
REQ-037 PUSH 16 times, then one more PUSH (DEPTH=16) -> full=1, err_code=2, tos unchanged.
REQ-038 cmd=7 with cmd_valid=1 -> err_code=3; reset asserted alongside PUSH -> count=0.

Source files
------------

// File: rtl/proc0_pkg.sv
// Shared constants for the operand stack: command codes, error codes and default geometry.
package proc0_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;

  localparam logic [2:0] CmdNop   = 3'd0;
  localparam logic [2:0] CmdPush  = 3'd1;
  localparam logic [2:0] CmdPop   = 3'd2;
  localparam logic [2:0] CmdDup   = 3'd3;
  localparam logic [2:0] CmdSwap  = 3'd4;
  localparam logic [2:0] CmdRepl2 = 3'd5;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrUnder   = 2'd1;
  localparam logic [1:0] ErrOver    = 2'd2;
  localparam logic [1:0] ErrIllegal = 2'd3;

endpackage

// File: rtl/stack_regfile.sv
// Backing storage for the entries below nos. Entry i holds stack position i (0 = bottom),
// so with count entries live the next write lands at count-2 and the entry just below
// nos is read from count-3.
module stack_regfile
  import proc0_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata
);

  localparam int unsigned Entries = DEPTH - 2;
  localparam int unsigned AW      = $clog2(Entries);
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [Entries];
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;

  assign waddr = AW'(count - CW'(2));
  assign raddr = AW'(count - CW'(3));

  // Async read; the caller masks the result when fewer than three entries are live.
  assign rdata = mem[raddr];

  // Single write port: spill the old nos when a new element goes on top.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/operand_stack.sv
// Operand stack with registered tos/nos and a register file for deeper entries.
// Optional macro OPERAND_STACK_TRAP_EN: errors become sticky and freeze the stack until reset.
module operand_stack
  import proc0_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       tos,
  output logic [WIDTH-1:0]       nos,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             rf_we;
  logic [WIDTH-1:0] rf_rdata;
  logic [WIDTH-1:0] below;
  logic [1:0]       code;
  logic             accept;

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (rf_we),
    .count (count_q),
    .wdata (nos_q),
    .rdata (rf_rdata)
  );

  // Entry below nos reads as zero when it does not exist.
  assign below = (count_q >= CW'(3)) ? rf_rdata : '0;

  // Classify the command; an illegal code wins over under/overflow.
  always_comb begin
    code = ErrNone;
    case (cmd)
      CmdNop:  code = ErrNone;
      CmdPush: if (count_q == CW'(DEPTH)) code = ErrOver;
      CmdPop:  if (count_q == '0) code = ErrUnder;
      CmdDup: begin
        if (count_q == '0) code = ErrUnder;
        else if (count_q == CW'(DEPTH)) code = ErrOver;
      end
      CmdSwap, CmdRepl2: if (count_q < CW'(2)) code = ErrUnder;
      default: code = ErrIllegal;
    endcase
  end

  // Next-state for the stack registers and the error reporting.
  always_comb begin
    tos_d   = tos_q;
    nos_d   = nos_q;
    count_d = count_q;
    rf_we   = 1'b0;
`ifdef OPERAND_STACK_TRAP_EN
    err_d      = err_q;
    err_code_d = err_code_q;
    accept     = cmd_valid && !err_q;
`else
    err_d      = 1'b0;
    err_code_d = ErrNone;
    accept     = cmd_valid;
`endif
    if (accept) begin
      if (code != ErrNone) begin
        err_d      = 1'b1;
        err_code_d = code;
      end else begin
        case (cmd)
          CmdPush: begin
            nos_d   = tos_q;
            tos_d   = din;
            count_d = count_q + CW'(1);
            rf_we   = (count_q >= CW'(2));
          end
          CmdPop: begin
            tos_d   = nos_q;
            nos_d   = below;
            count_d = count_q - CW'(1);
          end
          CmdDup: begin
            nos_d   = tos_q;
            count_d = count_q + CW'(1);
            rf_we   = (count_q >= CW'(2));
          end
          CmdSwap: begin
            tos_d = nos_q;
            nos_d = tos_q;
          end
          CmdRepl2: begin
            tos_d   = din;
            nos_d   = below;
            count_d = count_q - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // State registers with synchronous reset that overrides any command.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q      <= '0;
      nos_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      tos_q      <= tos_d;
      nos_q      <= nos_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign tos      = tos_q;
  assign nos      = nos_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
